// File: rtl/store.sv
// Store unit: single-cycle SW, read-modify-write SB/SH via IDLE/MERGE FSM.
// Optional misaligned-store detection under `STORE_MISALIGN_CHECK_EN.
module store (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rs1_val,
  input  logic [31:0] imm,
  input  logic [31:0] rs2_val,
  input  logic [1:0]  store_control,
  input  logic [31:0] mem_rdata,
  output logic        stall_pc,
  output logic        ignore_curr_inst,
  output logic        mem_rw_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        store_misaligned
);

  localparam logic [1:0] ST_NOP = 2'b00;
  localparam logic [1:0] ST_SB  = 2'b01;
  localparam logic [1:0] ST_SH  = 2'b10;
  localparam logic [1:0] ST_SW  = 2'b11;

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [29:0] waddr_q;
  logic [1:0]  off_q;
  logic [1:0]  type_q;
  logic [15:0] data_q;

  logic [31:0] ea;
  logic        mis;
  logic        rmw_go;
  logic [31:0] merged;

  assign ea = rs1_val + imm;

`ifdef STORE_MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if (store_control == ST_SH && ea[0])
      mis = 1'b1;
    if (store_control == ST_SW && ea[1:0] != 2'b00)
      mis = 1'b1;
  end
`else
  assign mis = 1'b0;
`endif

  assign rmw_go = (state_q == IDLE) && !mis &&
                  (store_control == ST_SB ||
                   store_control == ST_SH);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      type_q  <= ST_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rmw_go) begin
        waddr_q <= ea[31:2];
        off_q   <= ea[1:0];
        type_q  <= store_control;
        data_q  <= rs2_val[15:0];
      end
    end
  end

  // Replace only the target lane; other bytes come from the read.
  always_comb begin
    merged = mem_rdata;
    if (type_q == ST_SH) begin
      if (off_q[1])
        merged[31:16] = data_q;
      else
        merged[15:0] = data_q;
    end else begin
      merged[{off_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    stall_pc         = 1'b0;
    ignore_curr_inst = 1'b0;
    mem_rw_mode      = 1'b1;
    mem_addr         = '0;
    mem_wdata        = '0;
    store_misaligned = 1'b0;
    if (!i_rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mis) begin
            store_misaligned = 1'b1;
          end else begin
            unique case (1'b1)
              store_control == ST_SW: begin
                mem_rw_mode = 1'b0;
                mem_addr    = {ea[31:2], 2'b00};
                mem_wdata   = rs2_val;
              end
              store_control == ST_SB,
              store_control == ST_SH: begin
                mem_addr = {ea[31:2], 2'b00};
                stall_pc = 1'b1;
                state_d  = MERGE;
              end
              default: ;
            endcase
          end
        end
        MERGE: begin
          mem_rw_mode      = 1'b0;
          mem_addr         = {waddr_q, 2'b00};
          mem_wdata        = merged;
          ignore_curr_inst = 1'b1;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
